// File: rtl/effects_pipeline.sv
// effects_pipeline
//   Guitar effects chain on a stream of signed audio samples, one sample per
//   clk, no handshake. Path: input capture -> gain (Q.GAIN_FRAC multiply with
//   saturation) -> soft clipper -> one-pole low-pass tone filter.
//   A sample (and the gain_value present with it) captured at edge N appears
//   on out_sample after edge N+3.
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset; clears every stage and tone state
//   gain_value  unsigned gain, gain_value/2^GAIN_FRAC (2^GAIN_FRAC = unity)
//   sample      signed input sample
//   out_sample  signed processed sample (the tone filter state register)
module effects_pipeline #(
    parameter int SLEN       = 16,
    parameter int GAIN_W     = 10,
    parameter int GAIN_FRAC  = 4,
    parameter int KNEE       = 16384,
    parameter int CLIP_SHIFT = 2,
    parameter int TONE_SHIFT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GAIN_W-1:0]      gain_value,
    input  logic signed [SLEN-1:0] sample,
    output logic signed [SLEN-1:0] out_sample
);

    localparam int PW = SLEN + GAIN_W + 1;  // full signed product width

    localparam logic signed [SLEN-1:0] SMAX = {1'b0, {(SLEN-1){1'b1}}};
    localparam logic signed [SLEN-1:0] SMIN = {1'b1, {(SLEN-1){1'b0}}};
    localparam logic signed [PW-1:0]   QMAX = PW'(SMAX);
    localparam logic signed [PW-1:0]   QMIN = PW'(SMIN);
    localparam logic [SLEN:0]          KNEE_V = (SLEN+1)'(KNEE);

    // Input capture: sample and gain travel together so a gain change applies
    // to the sample taken on the same edge.
    logic signed [SLEN-1:0] s_in;
    logic [GAIN_W-1:0]      g_in;

    // Stage registers. C and T are one bit wider than a sample: |x| of the
    // most negative sample needs it in the clipper, and the tone difference
    // is formed directly from the widened values.
    logic signed [SLEN-1:0] g_reg;
    logic signed [SLEN:0]   c_reg;
    logic signed [SLEN:0]   t_reg;

    // ---------------- gain ----------------
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   q_full;
    logic signed [SLEN-1:0] g_next;

    assign prod   = PW'(s_in) * PW'($signed({1'b0, g_in}));
    assign q_full = prod >>> GAIN_FRAC;  // floor toward -inf

    always_comb begin
        g_next = q_full[SLEN-1:0];
        if (q_full > QMAX)      g_next = SMAX;
        else if (q_full < QMIN) g_next = SMIN;
    end

    // ---------------- soft clip ----------------
    logic signed [SLEN:0] xe;
    logic [SLEN:0]        mag;
    logic [SLEN:0]        y;
    logic signed [SLEN:0] c_next;

    assign xe     = {g_reg[SLEN-1], g_reg};
    assign mag    = xe[SLEN] ? $unsigned(-xe) : $unsigned(xe);
    assign y      = (mag <= KNEE_V) ? mag : KNEE_V + ((mag - KNEE_V) >> CLIP_SHIFT);
    assign c_next = xe[SLEN] ? -$signed(y) : $signed(y);

    // ---------------- tone (one-pole low-pass) ----------------
    // T moves a fraction 1/2^TONE_SHIFT of the way toward the input; the
    // result stays between old T and the input so it never overflows.
    logic signed [SLEN:0] d;
    logic signed [SLEN:0] step;
    logic signed [SLEN:0] t_next;

    assign d      = c_reg - t_reg;
    assign step   = d >>> TONE_SHIFT;
    assign t_next = t_reg + step;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_in  <= '0;
            g_in  <= '0;
            g_reg <= '0;
            c_reg <= '0;
            t_reg <= '0;
        end else begin
            s_in  <= sample;
            g_in  <= gain_value;
            g_reg <= g_next;
            c_reg <= c_next;
            t_reg <= t_next;
        end
    end

    assign out_sample = t_reg[SLEN-1:0];

endmodule

// File: tb/tb_effects_pipeline.sv
// tb_effects_pipeline
//   Two instances: default tone filter (u_def) and tone bypass (u_t0).
//   Directed table on the bypass instance, hand sequences for reset and tone
//   ramp, and a reference model for random streams around a mid-stream reset.
module tb_effects_pipeline;

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        gain;
    logic signed [15:0] smp;
    logic signed [15:0] out_def;
    logic signed [15:0] out_t0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    effects_pipeline u_def (
        .clk(clk), .rst(rst), .gain_value(gain), .sample(smp), .out_sample(out_def)
    );

    effects_pipeline #(.TONE_SHIFT(0)) u_t0 (
        .clk(clk), .rst(rst), .gain_value(gain), .sample(smp), .out_sample(out_t0)
    );

    typedef struct {
        string nm;
        int    g;
        int    s;
        int    exp;
    } vec_t;

    vec_t vt [17];

    // model state
    int tm_def;
    int tm_t0;
    int cq [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return int'(q);
    endfunction

    function automatic int m_gain(input int s, input int g);
        int q;
        q = fdiv(longint'(s) * longint'(g), 16);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic int m_clip(input int x);
        int m;
        int y;
        m = (x < 0) ? -x : x;
        y = (m <= 16384) ? m : 16384 + (m - 16384) / 4;
        return (x < 0) ? -y : y;
    endfunction

    task automatic model_reset();
        tm_def = 0;
        tm_t0  = 0;
        cq     = '{0, 0, 0};
    endtask

    // Advance the model by the edge just taken with the current inputs.
    task automatic model_edge();
        int x;
        if (rst) begin
            model_reset();
        end else begin
            cq.push_back(m_clip(m_gain(int'(smp), int'(gain))));
            x      = cq.pop_front();
            tm_def = tm_def + fdiv(longint'(x - tm_def), 4);
            tm_t0  = x;
        end
    endtask

    initial begin
        int exp_ramp [8];
        int prev;

        vt[0]  = '{"frac_12",     20,  12,     15};
        vt[1]  = '{"frac_0",      20,  0,      0};
        vt[2]  = '{"frac_1",      20,  1,      1};
        vt[3]  = '{"frac_4",      20,  4,      5};
        vt[4]  = '{"frac_13",     20,  13,     16};
        vt[5]  = '{"frac_40",     20,  40,     50};
        vt[6]  = '{"sat_pos",     1023, 32767, 20479};
        vt[7]  = '{"sat_neg",     1023, -32768, -20480};
        vt[8]  = '{"gain0_pos",   0,   12345,  0};
        vt[9]  = '{"gain0_neg",   0,   -32768, 0};
        vt[10] = '{"knee_eq",     16,  16384,  16384};
        vt[11] = '{"knee_above",  16,  20000,  17288};
        vt[12] = '{"knee_neg",    16,  -20000, -17288};
        vt[13] = '{"knee_plus1",  16,  16385,  16384};
        vt[14] = '{"floor_m1023", 1023, -1,    -64};
        vt[15] = '{"floor_m8",    8,   -1,     -1};
        vt[16] = '{"unity_neg1",  16,  -1,     -1};

        // ---- T1: reset held 3 cycles with arbitrary inputs ----
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gain = 10'($urandom_range(0, 1023));
            smp  = 16'($urandom);
            step();
            chk("rst_def", int'(out_def), 0);
            chk("rst_t0",  int'(out_t0),  0);
        end
        rst  = 1'b0;
        gain = 10'd16;
        smp  = 16'sd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_def", int'(out_def), 0);
            chk("idle_t0",  int'(out_t0),  0);
        end

        // ---- T2: unity gain, tone ramp on constant 1024 ----
        exp_ramp = '{0, 0, 0, 256, 448, 592, 700, 781};
        smp = 16'sd1024;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ramp_def", int'(out_def), exp_ramp[i]);
            if (i >= 3) chk("ramp_t0", int'(out_t0), 1024);
        end
        prev = int'(out_def);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("ramp_mono", int'((int'(out_def) >= prev) && (int'(out_def) <= 1024)), 1);
            prev = int'(out_def);
        end

        // ---- T3..T5: directed table on the bypass instance ----
        for (int i = 0; i < 17 + 3; i++) begin
            if (i < 17) begin
                gain = 10'(vt[i].g);
                smp  = 16'(vt[i].s);
            end
            step();
            if (i >= 3) chk(vt[i-3].nm, int'(out_t0), vt[i-3].exp);
        end

        // ---- T6: random stream, mid-stream reset, random stream ----
        rst = 1'b1;
        step();
        model_edge();
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            gain = 10'($urandom_range(0, 1023));
            smp  = 16'($urandom);
            step();
            model_edge();
            chk("rand_def", int'(out_def), tm_def);
            chk("rand_t0",  int'(out_t0),  tm_t0);
        end
        rst  = 1'b1;
        gain = 10'($urandom_range(1, 1023));
        smp  = 16'($urandom);
        step();
        model_edge();
        chk("midrst_def", int'(out_def), 0);
        chk("midrst_t0",  int'(out_t0),  0);
        rst  = 1'b0;
        gain = 10'd16;
        smp  = 16'sd1000;
        for (int i = 0; i < 4; i++) begin
            step();
            model_edge();
            smp = 16'sd0;
            chk("post_rst_t0",  int'(out_t0),  (i == 3) ? 1000 : 0);
            chk("post_rst_def", int'(out_def), (i == 3) ? 250 : 0);
        end
        for (int k = 0; k < 25; k++) begin
            gain = 10'($urandom_range(0, 1023));
            smp  = 16'($urandom);
            step();
            model_edge();
            chk("rand2_def", int'(out_def), tm_def);
            chk("rand2_t0",  int'(out_t0),  tm_t0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
